inv_mix_col_unit: RTL
=====================

Name: inv_mix_col_unit

Overview:
- Iterative AES InvMixColumns engine for the decrypt datapath; inverse of the forward per-column MixColumns.
- Accepts one 128-bit state via valid/ready and processes COLS_PER_CYCLE columns per clock.
- Returns the 128-bit result via valid/ready, with one state in flight.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4. Any other value must fail elaboration.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  unit can accept a state.
- in_data  input  128  state; column c = in_data[127-32c -: 32]; byte order within a column is row0 = [31:24] down to row3 = [7:0].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  InvMixColumns(in_data), same packing.
- busy  output  1  high when not IDLE.

Behaviour:
- Per-column arithmetic, over GF(2^8) with polynomial 0x11b:
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
  - Build the products from xtime chains (x2, x4, x8) and XOR. No lookup tables, no generic multiplier.
- N = 4/COLS_PER_CYCLE.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready: latch in_data into the state register, clear the column counter to 0, go to BUSY.
  - BUSY: each cycle, replace columns [cnt*C .. cnt*C+C-1] in place with their transformed values, then cnt += 1. On the cycle the last group is written, go to DONE. The counter never wraps beyond N-1.
  - DONE: out_valid=1 and out_data = state register, both held stable while out_ready=0. On out_valid&out_ready go to IDLE.
- Latency:
  - Acceptance at edge T gives out_valid high after edge T+N (T+4 at C=1, T+1 at C=4).
  - in_ready returns one cycle after the output handshake. There is no same-cycle accept/release overlap.
  - Throughput is one state per N+2 cycles when out_ready is tied high.
- in_data is ignored outside IDLE. in_valid may drop without consequence before acceptance.
- out_ready is ignored outside DONE.
- Reset values: state IDLE; in_ready=0 while rst=1 and 1 after; out_valid=0; out_data=0 (state register cleared); busy=0; cnt=0.
- Reset asserted in BUSY or DONE aborts the operation. The pending result is discarded, never presented, and out_data reads 0.
- Identity property: columns of equal bytes (aa aa aa aa) map to themselves.

Test Plan:
- C=1, in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_ready=1 -> out_data=db135345_f20a225c_01010101_c6c6c6c6; out_valid rises exactly 4 cycles after the accept edge; busy high throughout.
- C=4, in_data=d5d5d7d6_4d7ebdf8_c6c6c6c6_01010101 -> out_data=d4d4d4d5_2d26314c_c6c6c6c6_01010101; out_valid rises 1 cycle after accept.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready -> handshake, then in_ready=1 the next cycle.
- Reset mid-BUSY (C=1, rst at cycle 2 after accept) -> next cycle out_valid=0, out_data=0, busy=0, in_ready=1 after rst falls. No stale output ever appears.
- Back-to-back: two states streamed with out_ready=1 -> both results correct and in order; accept-to-accept spacing is N+2 cycles.
- Round trip: random 128-bit X through the forward mix_col per column, then this unit, for 1000 vectors -> output equals X.

Source files
------------

// File: rtl/inv_mix_col_unit.sv
// Iterative AES InvMixColumns engine: one 128-bit state in flight, COLS_PER_CYCLE
// columns transformed per clock, valid/ready on both sides.
module inv_mix_col_unit #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int C     = COLS_PER_CYCLE;
   localparam int N     = (C > 0) ? 4 / C : 1;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   generate
      if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
         $error("inv_mix_col_unit: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [127:0]       data_reg;
   logic [127:0]       data_next;
   logic [31:0]        cols      [4];
   logic [31:0]        col_in    [C];
   logic [31:0]        col_out   [C];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiples 9, b, d, e are built from the x2/x4/x8 chain of each byte.
   function automatic logic [31:0] inv_col(input logic [31:0] s);
      logic [7:0] b  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         b[i]  = s[31-8*i -: 8];
         x2    = xt(b[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ b[i];
         mb[i] = x8 ^ x2 ^ b[i];
         md[i] = x8 ^ x4 ^ b[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cols
         assign cols[gi] = data_reg[127-32*gi -: 32];
      end

      // Lane gi of the current group works on column cnt*C + gi.
      for (genvar gi = 0; gi < C; gi++) begin : g_lane
         logic [1:0] idx;
         assign idx         = 2'(int'(cnt_reg) * C + gi);
         assign col_in[gi]  = cols[idx];
         assign col_out[gi] = inv_col(col_in[gi]);
      end

      for (genvar gi = 0; gi < 4; gi++) begin : g_wb
         logic hit;
         assign hit = (cnt_reg == CNT_W'(gi / C));
         assign data_next[127-32*gi -: 32] = hit ? col_out[gi % C] : cols[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         data_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  data_reg  <= in_data;
                  cnt_reg   <= '0;
                  state_reg <= S_BUSY;
               end
            end
            S_BUSY: begin
               data_reg <= data_next;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == S_IDLE) && !rst;
   assign out_valid = (state_reg == S_DONE);
   assign busy      = (state_reg != S_IDLE);
   assign out_data  = data_reg;

endmodule
